// File: rtl/hazard_stall_controller_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs going in and pipeline
// control outputs coming back. The pipeline side uses master and the
// controller uses slave.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_RegRs;
    logic [4:0]       ID_RegRt;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic             ID_Branch;
    logic             ID_MulDiv;
    logic             ID_ReadsHiLo;
    logic             BranchTaken;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [4:0]       EX_Rd;
    logic             MEM_MemRead;
    logic [4:0]       MEM_Rd;
    logic             PCWrite;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             MulBusy;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output ID_RegRs, ID_RegRt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_MulDiv,
               ID_ReadsHiLo, BranchTaken, EX_MemRead, EX_RegWrite, EX_Rd,
               MEM_MemRead, MEM_Rd,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, MulBusy, StallCycles
    );

    modport slave (
        input  ID_RegRs, ID_RegRt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_MulDiv,
               ID_ReadsHiLo, BranchTaken, EX_MemRead, EX_RegWrite, EX_Rd,
               MEM_MemRead, MEM_Rd,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, MulBusy, StallCycles
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard stall sequencer for the 5-stage MIPS pipeline. It covers load-use,
// branch operand dependencies resolved in ID, and mult/div / HI-LO occupancy.
// It also keeps a saturating count of stall cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | mult/div unit idle; a mult/div in ID may issue
// MD_BUSY | mult/div executing; MdCnt counts remaining busy cycles
module hazard_stall_controller #(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    hazard_stall_controller_if.slave bus
);

    typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} mdState_t;

    mdState_t         state, nextState;
    logic [7:0]       mdCnt, nextMdCnt;
    logic [CNT_W-1:0] stallCnt;
    logic             loadUse, brDep, mdHaz, stall, mulBusy;

    function automatic logic matchX(input logic [4:0] r,
                                    input logic [4:0] rs, input logic usesRs,
                                    input logic [4:0] rt, input logic usesRt);
        return (r != 5'd0) && ((usesRs && rs == r) || (usesRt && rt == r));
    endfunction

    // Hazard detection: every term is combinational, so a stall takes effect in the same cycle.
    always_comb begin
        mulBusy = (state == MD_BUSY);
        loadUse = bus.EX_MemRead &&
                  matchX(bus.EX_Rd, bus.ID_RegRs, bus.ID_UsesRs, bus.ID_RegRt, bus.ID_UsesRt);
        brDep   = bus.ID_Branch &&
                  ((bus.EX_RegWrite &&
                    matchX(bus.EX_Rd, bus.ID_RegRs, bus.ID_UsesRs, bus.ID_RegRt, bus.ID_UsesRt)) ||
                   (bus.MEM_MemRead &&
                    matchX(bus.MEM_Rd, bus.ID_RegRs, bus.ID_UsesRs, bus.ID_RegRt, bus.ID_UsesRt)));
        mdHaz   = mulBusy && (bus.ID_MulDiv || bus.ID_ReadsHiLo);
        stall   = loadUse || brDep || mdHaz;
    end

    // A stalled branch is re-evaluated later, so a stall suppresses the taken-branch flush.
    assign bus.PCWrite     = !stall;
    assign bus.IFID_Write  = !stall;
    assign bus.IDEX_Flush  = stall;
    assign bus.IFID_Flush  = bus.BranchTaken && !stall;
    assign bus.MulBusy     = mulBusy;
    assign bus.StallCycles = stallCnt;

    // Mult/div FSM state register and busy down-counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RUN;
            mdCnt <= 8'd0;
        end else begin
            state <= nextState;
            mdCnt <= nextMdCnt;
        end
    end

    // Mult/div next state. A mult/div that is stalled by some other hazard is not issued; it is retried on the next cycle.
    always_comb begin
        nextState = state;
        nextMdCnt = mdCnt;
        case (state)
            RUN: begin
                if (bus.ID_MulDiv && !stall) begin
                    nextState = MD_BUSY;
                    nextMdCnt = 8'(MULDIV_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                if (mdCnt == 8'd0) nextState = RUN;
                else               nextMdCnt = mdCnt - 8'd1;
            end
            default: nextState = RUN;
        endcase
    end

    // Stall-cycle counter. It saturates at all-ones instead of wrapping.
    always_ff @(posedge Clk) begin
        if (Reset)
            stallCnt <= '0;
        else if (stall && (stallCnt != {CNT_W{1'b1}}))
            stallCnt <= stallCnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. It runs a table of single-cycle
// hazard vectors, then hand-written mult/div, reset and saturation sequences.
module tb_hazard_stall_controller;

    logic Clk = 1'b0;
    logic Reset;
    int   nVec = 0;
    int   nMis = 0;

    hazard_stall_controller_if #(.CNT_W(16)) hsIf ();
    hazard_stall_controller_if #(.CNT_W(4))  satIf ();

    hazard_stall_controller #(.MULDIV_CYCLES(4), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .bus(hsIf.slave));
    hazard_stall_controller #(.MULDIV_CYCLES(4), .CNT_W(4)) dutSat (
        .Clk(Clk), .Reset(Reset), .bus(satIf.slave));

    assign satIf.ID_RegRs     = hsIf.ID_RegRs;
    assign satIf.ID_RegRt     = hsIf.ID_RegRt;
    assign satIf.ID_UsesRs    = hsIf.ID_UsesRs;
    assign satIf.ID_UsesRt    = hsIf.ID_UsesRt;
    assign satIf.ID_Branch    = hsIf.ID_Branch;
    assign satIf.ID_MulDiv    = hsIf.ID_MulDiv;
    assign satIf.ID_ReadsHiLo = hsIf.ID_ReadsHiLo;
    assign satIf.BranchTaken  = hsIf.BranchTaken;
    assign satIf.EX_MemRead   = hsIf.EX_MemRead;
    assign satIf.EX_RegWrite  = hsIf.EX_RegWrite;
    assign satIf.EX_Rd        = hsIf.EX_Rd;
    assign satIf.MEM_MemRead  = hsIf.MEM_MemRead;
    assign satIf.MEM_Rd       = hsIf.MEM_Rd;

    // 10 ns system clock.
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRs;
        logic       usesRt;
        logic       branch;
        logic       mulDiv;
        logic       hiLo;
        logic       taken;
        logic       exMemRead;
        logic       exRegWrite;
        logic [4:0] exRd;
        logic       memMemRead;
        logic [4:0] memRd;
        logic       expStall;
        logic       expIfidFlush;
        int         expCnt;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            nMis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkCtl(input string tag, input logic expStall, input logic expFlush,
                          input logic expBusy, input int expCnt);
        nVec++;
        chk({tag, " PCWrite"},     int'(hsIf.PCWrite),    int'(!expStall));
        chk({tag, " IFID_Write"},  int'(hsIf.IFID_Write), int'(!expStall));
        chk({tag, " IDEX_Flush"},  int'(hsIf.IDEX_Flush), int'(expStall));
        chk({tag, " IFID_Flush"},  int'(hsIf.IFID_Flush), int'(expFlush));
        chk({tag, " MulBusy"},     int'(hsIf.MulBusy),    int'(expBusy));
        chk({tag, " StallCycles"}, int'(hsIf.StallCycles), expCnt);
    endtask

    task automatic clearIn();
        hsIf.ID_RegRs = 5'd0;  hsIf.ID_RegRt = 5'd0;
        hsIf.ID_UsesRs = 1'b0; hsIf.ID_UsesRt = 1'b0;
        hsIf.ID_Branch = 1'b0; hsIf.ID_MulDiv = 1'b0; hsIf.ID_ReadsHiLo = 1'b0;
        hsIf.BranchTaken = 1'b0;
        hsIf.EX_MemRead = 1'b0; hsIf.EX_RegWrite = 1'b0; hsIf.EX_Rd = 5'd0;
        hsIf.MEM_MemRead = 1'b0; hsIf.MEM_Rd = 5'd0;
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        clearIn();
        Reset = 1'b1;
        nextCycle();
        Reset = 1'b0;
    endtask

    initial begin
        //            rs  rt uRs uRt br  md  hl  tk  exR exW exRd mR  mRd  stl fl  cnt
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 0, 0, 0};
        vecs[1]  = '{5'd8, 5'd0, 1, 0, 0, 0, 0, 0, 1, 0, 5'd8,  0, 5'd0, 1, 0, 0};
        vecs[2]  = '{5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 1, 0, 5'd0,  0, 5'd0, 0, 0, 1};
        vecs[3]  = '{5'd0, 5'd9, 0, 1, 1, 0, 0, 1, 0, 0, 5'd0,  1, 5'd9, 1, 0, 1};
        vecs[4]  = '{5'd0, 5'd9, 0, 1, 1, 0, 0, 1, 0, 0, 5'd0,  0, 5'd9, 0, 1, 2};
        vecs[5]  = '{5'd8, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd8,  0, 5'd0, 0, 0, 2};
        vecs[6]  = '{5'd0, 5'd12,0, 1, 0, 0, 0, 0, 1, 0, 5'd12, 0, 5'd0, 1, 0, 2};
        vecs[7]  = '{5'd5, 5'd0, 1, 0, 1, 0, 0, 1, 0, 1, 5'd5,  0, 5'd0, 1, 0, 3};
        vecs[8]  = '{5'd5, 5'd0, 1, 0, 0, 0, 0, 0, 0, 1, 5'd5,  0, 5'd0, 0, 0, 4};
        vecs[9]  = '{5'd7, 5'd0, 1, 0, 1, 0, 0, 0, 1, 1, 5'd7,  0, 5'd0, 1, 0, 4};
        vecs[10] = '{5'd0, 5'd9, 0, 1, 0, 0, 0, 0, 0, 0, 5'd0,  1, 5'd9, 0, 0, 5};
        vecs[11] = '{5'd3, 5'd0, 1, 0, 0, 1, 0, 0, 1, 0, 5'd3,  0, 5'd0, 1, 0, 5};
        vecs[12] = '{5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd0,  0, 5'd0, 0, 0, 6};
        vecs[13] = '{5'd0, 5'd0, 1, 0, 1, 0, 0, 0, 0, 1, 5'd0,  0, 5'd0, 0, 0, 6};
        vecs[14] = '{5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd0,  0, 5'd0, 0, 1, 6};

        doReset();
        @(negedge Clk);
        chkCtl("reset", 1'b0, 1'b0, 1'b0, 0);
        chk("reset sat StallCycles", int'(satIf.StallCycles), 0);
        nextCycle();

        // Single-cycle hazard table; none of these issue a mult/div.
        for (int i = 0; i < 15; i++) begin
            hsIf.ID_RegRs     = vecs[i].rs;
            hsIf.ID_RegRt     = vecs[i].rt;
            hsIf.ID_UsesRs    = vecs[i].usesRs;
            hsIf.ID_UsesRt    = vecs[i].usesRt;
            hsIf.ID_Branch    = vecs[i].branch;
            hsIf.ID_MulDiv    = vecs[i].mulDiv;
            hsIf.ID_ReadsHiLo = vecs[i].hiLo;
            hsIf.BranchTaken  = vecs[i].taken;
            hsIf.EX_MemRead   = vecs[i].exMemRead;
            hsIf.EX_RegWrite  = vecs[i].exRegWrite;
            hsIf.EX_Rd        = vecs[i].exRd;
            hsIf.MEM_MemRead  = vecs[i].memMemRead;
            hsIf.MEM_Rd       = vecs[i].memRd;
            @(negedge Clk);
            chkCtl($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].expIfidFlush, 1'b0,
                   vecs[i].expCnt);
            nextCycle();
        end
        clearIn();
        @(negedge Clk);
        chkCtl("table end", 1'b0, 1'b0, 1'b0, 6);

        // Mult/div issue followed by a HI/LO reader waiting out the busy window.
        doReset();
        hsIf.ID_MulDiv = 1'b1;
        @(negedge Clk);
        chkCtl("md issue", 1'b0, 1'b0, 1'b0, 0);
        nextCycle();
        hsIf.ID_MulDiv    = 1'b0;
        hsIf.ID_ReadsHiLo = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            chkCtl($sformatf("md busy t+%0d", k), 1'b1, 1'b0, 1'b1, k - 1);
            nextCycle();
        end
        @(negedge Clk);
        chkCtl("md done t+5", 1'b0, 1'b0, 1'b0, 4);
        nextCycle();

        // A second mult/div during busy waits, then issues in the first RUN cycle.
        clearIn();
        doReset();
        hsIf.ID_MulDiv = 1'b1;
        nextCycle();
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            chkCtl($sformatf("md2 wait t+%0d", k), 1'b1, 1'b0, 1'b1, k - 1);
            nextCycle();
        end
        @(negedge Clk);
        chkCtl("md2 issue t+5", 1'b0, 1'b0, 1'b0, 4);
        nextCycle();
        hsIf.ID_MulDiv = 1'b0;
        @(negedge Clk);
        chkCtl("md2 busy t+6", 1'b0, 1'b0, 1'b1, 4);

        // Reset in the middle of the busy window.
        clearIn();
        doReset();
        hsIf.ID_MulDiv = 1'b1;
        nextCycle();
        hsIf.ID_MulDiv    = 1'b0;
        hsIf.ID_ReadsHiLo = 1'b1;
        @(negedge Clk);
        chkCtl("rst t+1", 1'b1, 1'b0, 1'b1, 0);
        nextCycle();
        @(negedge Clk);
        chkCtl("rst t+2", 1'b1, 1'b0, 1'b1, 1);
        Reset = 1'b1;
        nextCycle();
        Reset = 1'b0;
        @(negedge Clk);
        chkCtl("rst t+3", 1'b0, 1'b0, 1'b0, 0);
        nextCycle();
        @(negedge Clk);
        chkCtl("rst t+4", 1'b0, 1'b0, 1'b0, 0);

        // Hold a load-use for 20 cycles; the 4-bit counter saturates at 15.
        clearIn();
        doReset();
        hsIf.EX_MemRead = 1'b1;
        hsIf.EX_Rd      = 5'd8;
        hsIf.ID_RegRs   = 5'd8;
        hsIf.ID_UsesRs  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            nVec++;
            chk($sformatf("sat cnt after %0d", k), int'(satIf.StallCycles), (k < 15) ? k : 15);
            chk($sformatf("wide cnt after %0d", k), int'(hsIf.StallCycles), k);
            nextCycle();
        end
        clearIn();
        @(negedge Clk);
        nVec++;
        chk("sat cnt final", int'(satIf.StallCycles), 15);
        chk("wide cnt final", int'(hsIf.StallCycles), 20);
        chk("sat PCWrite final", int'(satIf.PCWrite), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
